rete_response_checker: RTL and testbench

- Synthesizable response checker: the receiving end of a stimulus/response exchange with a 2-input, 1-output combinational net.
- It accepts observed vectors ({a,b} applied, c observed) through a valid/ready handshake.
- Each c is compared against a parameterised truth table. The block counts vectors and mismatches, captures the first failing vector, and reports pass/fail and timeout at the end of a run.
- It sits beside the net under test, fed by a stimulus sequencer.

---
 rtl/rete_check_pkg.sv | 13 +
 rtl/rete_response_checker_sat_counter.sv | 35 +++
 rtl/rete_response_checker.sv | 141 ++++++++++++++
 tb/tb_rete_response_checker.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rete_check_pkg.sv
// Shared definitions for the response checker: FSM states and default truth table.
package rete_check_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // Expected c indexed by {a,b}: NAND gives 00->1, 01->1, 10->1, 11->0.
    localparam logic [3:0] EXP_NAND = 4'b0111;

endpackage

// File: rtl/rete_response_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned CW = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          clear,
    input  logic          inc,
    output logic [CW-1:0] count
);

    logic [CW-1:0] count_q, count_d;

    // Next count: clear has priority, increments stop at the maximum value.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != '1)) begin
            count_d = count_q + CW'(1);
        end
    end

    // Count register.
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/rete_response_checker.sv
// Response checker: accepts observed {a,b}/c vectors, compares c against a truth
// table, counts vectors and mismatches, captures the first mismatch and reports
// pass/timeout at the end of each run.
module rete_response_checker
    import rete_check_pkg::*;
#(
    parameter int unsigned NUM_VEC   = 4,
    parameter logic [3:0]  EXP_TABLE = EXP_NAND,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned CW        = 8
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [1:0]    in_ab,
    input  logic          in_c,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic          timeout,
    output logic [CW-1:0] vec_count,
    output logic [CW-1:0] err_count,
    output logic [1:0]    first_err_ab,
    output logic          first_err_c,
    output logic          first_err_valid
);

    localparam int unsigned   IW         = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_VEC   = CW'(NUM_VEC);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT);

    state_e        state_q, state_d;
    logic [CW-1:0] vec_q, vec_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          timeout_q, timeout_d;
    logic [1:0]    fe_ab_q, fe_ab_d;
    logic          fe_c_q, fe_c_d;
    logic          fe_valid_q, fe_valid_d;

    logic          start_run;
    logic          xfer;
    logic          mismatch;
    logic          err_inc;

    // Next-state and datapath updates for the run sequencing.
    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        idle_d     = idle_q;
        timeout_d  = timeout_q;
        fe_ab_d    = fe_ab_q;
        fe_c_d     = fe_c_q;
        fe_valid_d = fe_valid_q;
        start_run  = 1'b0;
        xfer       = in_valid && (state_q == S_RUN);
        mismatch   = (in_c != EXP_TABLE[in_ab]);
        err_inc    = xfer && mismatch;

        case (state_q)
            S_RUN: begin
                if (xfer) begin
                    vec_d  = vec_q + CW'(1);
                    idle_d = '0;
                    if (mismatch && !fe_valid_q) begin
                        fe_ab_d    = in_ab;
                        fe_c_d     = in_c;
                        fe_valid_d = 1'b1;
                    end
                    // The final transfer wins over a coincident idle expiry since
                    // a transfer never advances the idle counter.
                    if (vec_q + CW'(1) == LAST_VEC) begin
                        state_d = S_DONE;
                    end
                end else begin
                    idle_d = idle_q + IW'(1);
                    if (idle_q + IW'(1) == IDLE_LIMIT) begin
                        state_d   = S_DONE;
                        timeout_d = 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    state_d    = S_RUN;
                    start_run  = 1'b1;
                    vec_d      = '0;
                    idle_d     = '0;
                    timeout_d  = 1'b0;
                    fe_ab_d    = '0;
                    fe_c_d     = 1'b0;
                    fe_valid_d = 1'b0;
                end
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            vec_q      <= '0;
            idle_q     <= '0;
            timeout_q  <= 1'b0;
            fe_ab_q    <= '0;
            fe_c_q     <= 1'b0;
            fe_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            idle_q     <= idle_d;
            timeout_q  <= timeout_d;
            fe_ab_q    <= fe_ab_d;
            fe_c_q     <= fe_c_d;
            fe_valid_q <= fe_valid_d;
        end
    end

    sat_counter #(
        .CW(CW)
    ) u_err_cnt (
        .clock(clock),
        .reset(reset),
        .clear(start_run),
        .inc  (err_inc),
        .count(err_count)
    );

    // Status outputs decode only registered state.
    assign in_ready        = (state_q == S_RUN);
    assign busy            = (state_q == S_RUN);
    assign done            = (state_q == S_DONE);
    assign pass            = (state_q == S_DONE) && (err_count == '0) && !timeout_q;
    assign timeout         = timeout_q;
    assign vec_count       = vec_q;
    assign first_err_ab    = fe_ab_q;
    assign first_err_c     = fe_c_q;
    assign first_err_valid = fe_valid_q;

endmodule

// File: tb/tb_rete_response_checker.sv
// Self-checking bench for rete_response_checker against a NAND-rule reference model.
module tb_rete_response_checker;

    localparam int unsigned NV = 4;
    localparam int unsigned TO = 16;

    logic       clock = 1'b0;
    logic       reset, start, in_valid, in_c;
    logic [1:0] in_ab;
    logic       in_ready, busy, done, pass, timeout;
    logic [7:0] vec_count, err_count;
    logic [1:0] first_err_ab;
    logic       first_err_c, first_err_valid;

    logic       start_s, in_valid_s, in_c_s;
    logic [1:0] in_ab_s;
    logic       in_ready_s, busy_s, done_s, pass_s, timeout_s;
    logic [1:0] vec_count_s, err_count_s;
    logic [1:0] first_err_ab_s;
    logic       first_err_c_s, first_err_valid_s;

    logic       sc_clear, sc_inc;
    logic [1:0] sc_count;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state, updated per accepted vector.
    int         m_vec, m_err;
    logic       m_fev, m_fc, m_to;
    logic [1:0] m_fab;

    always #5 clock = ~clock;

    rete_response_checker #(
        .NUM_VEC(NV), .EXP_TABLE(4'b0111), .TIMEOUT(TO), .CW(8)
    ) dut (
        .clock(clock), .reset(reset), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .in_ab(in_ab), .in_c(in_c), .busy(busy),
        .done(done), .pass(pass), .timeout(timeout), .vec_count(vec_count),
        .err_count(err_count), .first_err_ab(first_err_ab),
        .first_err_c(first_err_c), .first_err_valid(first_err_valid)
    );

    rete_response_checker #(
        .NUM_VEC(3), .EXP_TABLE(4'b0111), .TIMEOUT(TO), .CW(2)
    ) dut_small (
        .clock(clock), .reset(reset), .start(start_s), .in_valid(in_valid_s),
        .in_ready(in_ready_s), .in_ab(in_ab_s), .in_c(in_c_s), .busy(busy_s),
        .done(done_s), .pass(pass_s), .timeout(timeout_s), .vec_count(vec_count_s),
        .err_count(err_count_s), .first_err_ab(first_err_ab_s),
        .first_err_c(first_err_c_s), .first_err_valid(first_err_valid_s)
    );

    sat_counter #(.CW(2)) u_sat (
        .clock(clock), .reset(reset), .clear(sc_clear), .inc(sc_inc), .count(sc_count)
    );

    function automatic logic nand_ref(input logic [1:0] ab);
        return !(ab[1] && ab[0]);
    endfunction

    function automatic logic [24:0] observed();
        return {in_ready, busy, done, pass, timeout, first_err_valid, first_err_ab,
                first_err_c, vec_count, err_count};
    endfunction

    function automatic logic [24:0] expected(input logic running, input logic finished);
        logic p;
        p = finished && (m_err == 0) && !m_to;
        return {running, running, finished, p, m_to, m_fev, m_fab, m_fc,
                8'(m_vec), 8'(m_err)};
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic model_clear();
        m_vec = 0; m_err = 0; m_fev = 1'b0; m_fab = 2'b00; m_fc = 1'b0; m_to = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        model_clear();
    endtask

    task automatic send(input logic [1:0] ab, input logic c);
        in_valid = 1'b1; in_ab = ab; in_c = c;
        step();
        in_valid = 1'b0;
        m_vec++;
        if (c != nand_ref(ab)) begin
            if (!m_fev) begin
                m_fev = 1'b1; m_fab = ab; m_fc = c;
            end
            m_err++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_ab = 2'b00; in_c = 1'b0;
        start_s = 1'b0; in_valid_s = 1'b0; in_ab_s = 2'b00; in_c_s = 1'b0;
        sc_clear = 1'b0; sc_inc = 1'b0;
        step(); step();
        start = 1'b1;
        step();
        reset = 1'b0; start = 1'b0;
        model_clear();
        n_cmp++;
        if (observed() !== expected(1'b0, 1'b0)) begin
            n_err++; $display("FAIL reset_state: got %h want %h", observed(), expected(1'b0, 1'b0));
        end
        step();
        n_cmp++;
        if (observed() !== expected(1'b0, 1'b0)) begin
            n_err++; $display("FAIL reset_hold: got %h want %h", observed(), expected(1'b0, 1'b0));
        end
    endtask

    task automatic test_pass_run();
        do_start();
        n_cmp++;
        if (observed() !== expected(1'b1, 1'b0)) begin
            n_err++; $display("FAIL run_entry: got %h want %h", observed(), expected(1'b1, 1'b0));
        end
        send(2'b00, 1'b1); send(2'b11, 1'b0); send(2'b10, 1'b1);
        n_cmp++;
        if (observed() !== expected(1'b1, 1'b0)) begin
            n_err++; $display("FAIL run_mid: got %h want %h", observed(), expected(1'b1, 1'b0));
        end
        send(2'b11, 1'b0);
        n_cmp++;
        if (observed() !== expected(1'b0, 1'b1)) begin
            n_err++; $display("FAIL pass_run: got %h want %h", observed(), expected(1'b0, 1'b1));
        end
    endtask

    task automatic test_errors();
        do_start();
        send(2'b00, 1'b1); send(2'b11, 1'b1); send(2'b10, 1'b1); send(2'b11, 1'b1);
        n_cmp++;
        if (observed() !== expected(1'b0, 1'b1)) begin
            n_err++; $display("FAIL error_run: got %h want %h", observed(), expected(1'b0, 1'b1));
        end
        n_cmp++;
        if ({err_count, first_err_ab, first_err_c, pass} !== {8'd2, 2'b11, 1'b1, 1'b0}) begin
            n_err++; $display("FAIL error_fields: got %h want %h",
                              {err_count, first_err_ab, first_err_c, pass}, {8'd2, 2'b11, 1'b1, 1'b0});
        end
    endtask

    task automatic test_ignore_and_restart();
        in_valid = 1'b1; in_ab = 2'b11; in_c = 1'b1;
        repeat (3) step();
        in_valid = 1'b0;
        n_cmp++;
        if (observed() !== expected(1'b0, 1'b1)) begin
            n_err++; $display("FAIL done_ignore: got %h want %h", observed(), expected(1'b0, 1'b1));
        end
        do_start();
        n_cmp++;
        if (observed() !== expected(1'b1, 1'b0)) begin
            n_err++; $display("FAIL restart_clear: got %h want %h", observed(), expected(1'b1, 1'b0));
        end
        send(2'b01, 1'b1); send(2'b11, 1'b0); send(2'b00, 1'b1); send(2'b10, 1'b1);
        n_cmp++;
        if (observed() !== expected(1'b0, 1'b1) || pass !== 1'b1) begin
            n_err++; $display("FAIL restart_pass: got %h want %h", observed(), expected(1'b0, 1'b1));
        end
        reset = 1'b1; step(); reset = 1'b0;
        model_clear();
        in_valid = 1'b1; in_ab = 2'b01; in_c = 1'b0;
        repeat (3) step();
        in_valid = 1'b0;
        n_cmp++;
        if (observed() !== expected(1'b0, 1'b0)) begin
            n_err++; $display("FAIL idle_ignore: got %h want %h", observed(), expected(1'b0, 1'b0));
        end
    endtask

    task automatic test_timeout();
        do_start();
        send(2'b00, 1'b1); send(2'b01, 1'b1);
        repeat (TO - 1) step();
        n_cmp++;
        if (observed() !== expected(1'b1, 1'b0)) begin
            n_err++; $display("FAIL timeout_early: got %h want %h", observed(), expected(1'b1, 1'b0));
        end
        step();
        m_to = 1'b1;
        n_cmp++;
        if (observed() !== expected(1'b0, 1'b1)) begin
            n_err++; $display("FAIL timeout_run: got %h want %h", observed(), expected(1'b0, 1'b1));
        end
    endtask

    task automatic test_reset_midrun();
        do_start();
        send(2'b00, 1'b0); send(2'b01, 1'b1);
        reset = 1'b1; step(); reset = 1'b0;
        model_clear();
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (observed() !== expected(1'b0, 1'b0)) begin
                n_err++; $display("FAIL reset_midrun[%0d]: got %h want %h", i, observed(), expected(1'b0, 1'b0));
            end
            step();
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 25; r++) begin
            logic to_run;
            int   nvec;
            do_start();
            to_run = ($urandom_range(0, 3) == 0);
            nvec   = to_run ? int'($urandom_range(0, NV - 1)) : int'(NV);
            for (int v = 0; v < nvec; v++) begin
                logic [1:0] ab;
                int gap;
                gap = int'($urandom_range(0, 5));
                for (int g = 0; g < gap; g++) begin
                    start = ($urandom_range(0, 3) == 0);
                    step();
                end
                start = 1'b0;
                ab = 2'($urandom_range(0, 3));
                send(ab, nand_ref(ab) ^ ($urandom_range(0, 2) == 0));
            end
            if (to_run) begin
                repeat (TO) step();
                m_to = 1'b1;
            end
            n_cmp++;
            if (observed() !== expected(1'b0, 1'b1)) begin
                n_err++; $display("FAIL random_run[%0d]: got %h want %h", r, observed(), expected(1'b0, 1'b1));
            end
        end
    endtask

    task automatic test_small_width();
        start_s = 1'b1; step(); start_s = 1'b0;
        in_valid_s = 1'b1;
        in_ab_s = 2'b00; in_c_s = 1'b0; step();
        in_ab_s = 2'b11; in_c_s = 1'b1; step();
        in_ab_s = 2'b01; in_c_s = 1'b0; step();
        in_valid_s = 1'b0;
        n_cmp++;
        if ({done_s, pass_s, vec_count_s, err_count_s, first_err_ab_s, first_err_c_s}
            !== {1'b1, 1'b0, 2'd3, 2'd3, 2'b00, 1'b0}) begin
            n_err++; $display("FAIL small_width: got %h want %h",
                              {done_s, pass_s, vec_count_s, err_count_s, first_err_ab_s, first_err_c_s},
                              {1'b1, 1'b0, 2'd3, 2'd3, 2'b00, 1'b0});
        end
    endtask

    task automatic test_saturation();
        sc_clear = 1'b1; step(); sc_clear = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            logic [1:0] want;
            sc_inc = 1'b1; step();
            want = (i > 3) ? 2'd3 : 2'(i);
            n_cmp++;
            if (sc_count !== want) begin
                n_err++; $display("FAIL saturate[%0d]: got %0d want %0d", i, sc_count, want);
            end
        end
        sc_inc = 1'b0;
        sc_clear = 1'b1; step(); sc_clear = 1'b0;
        n_cmp++;
        if (sc_count !== 2'd0) begin
            n_err++; $display("FAIL sat_clear: got %0d want 0", sc_count);
        end
    endtask

    initial begin
        @(negedge clock);
        test_reset();
        test_pass_run();
        test_errors();
        test_ignore_and_restart();
        test_timeout();
        test_reset_midrun();
        test_random();
        test_small_width();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
